// File: rtl/opacc_core.sv
// Outer-product accumulate tile: ml x vl matrix C, C += A (x) B, with a row-shift load that drains old C on vo_c.
// Optional OPACC_BUSY_EN macro adds a `busy` output.
module opacc_core #(
    parameter int XLEN = 64,
    parameter int vl   = 2,
    parameter int ml   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 c_valid,
    input  logic                 ab_valid,
    input  logic [ml*XLEN-1:0]   vi_a,
    input  logic [vl*XLEN-1:0]   vi_b,
    input  logic [vl*XLEN-1:0]   vi_c,
    output logic [vl*XLEN-1:0]   vo_c,
    output logic                 en_c,
    output logic                 en_ab
`ifdef OPACC_BUSY_EN
    ,
    output logic                 busy
`endif
);

    typedef enum logic {IDLE = 1'b0, LOAD_C = 1'b1} state_t;
    localparam int CW = (ml > 1) ? $clog2(ml) : 1;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic [ml-1:0][vl-1:0][XLEN-1:0] reg_c, c_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // c_valid seen while loading is dropped: only IDLE looks at it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (c_valid) begin
                    state_nxt = LOAD_C;
                    cnt_nxt   = '0;
                end
            end
            LOAD_C: begin
                if (cnt == CW'(ml - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        en_c  = (state == LOAD_C);
        en_ab = ab_valid && (state == IDLE) && !c_valid;
`ifdef OPACC_BUSY_EN
        busy  = (state == LOAD_C) || c_valid;
`endif
    end

    // Load shifts rows toward row 0 so the old C drains out while the new one fills in.
    always_comb begin
        c_nxt = reg_c;
        if (en_c) begin
            for (int r = 0; r < ml - 1; r++)
                c_nxt[r] = reg_c[r + 1];
            c_nxt[ml-1] = vi_c;
        end else if (en_ab) begin
            for (int r = 0; r < ml; r++)
                for (int j = 0; j < vl; j++)
                    c_nxt[r][j] = reg_c[r][j] + vi_a[r*XLEN +: XLEN] * vi_b[j*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) reg_c <= '0;
        else          reg_c <= c_nxt;
    end

    assign vo_c = reg_c[0];

endmodule

// File: tb/tb_opacc_core.sv
// Self-checking bench for opacc_core: directed scenarios plus random traffic against a row-array reference model.
module tb_opacc_core;
    localparam int XLEN = 64;
    localparam int vl   = 2;
    localparam int ml   = 2;
    localparam int W    = vl * XLEN;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               c_valid, ab_valid;
    logic [ml*XLEN-1:0] vi_a;
    logic [W-1:0]       vi_b, vi_c, vo_c;
    logic               en_c, en_ab;
`ifdef OPACC_BUSY_EN
    logic               busy;
`endif

    opacc_core #(.XLEN(XLEN), .vl(vl), .ml(ml)) dut (
        .clk(clk), .reset_n(reset_n), .c_valid(c_valid), .ab_valid(ab_valid),
        .vi_a(vi_a), .vi_b(vi_b), .vi_c(vi_c), .vo_c(vo_c), .en_c(en_c), .en_ab(en_ab)
`ifdef OPACC_BUSY_EN
        , .busy(busy)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference: C as a plain 2-D array, load progress as "rows still to come".
    bit [XLEN-1:0] m_c[ml][vl];
    int            load_left;
    logic [W-1:0]  obs_vo;
    logic          obs_en_c;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pk(input bit [XLEN-1:0] e1, input bit [XLEN-1:0] e0);
        return {e1, e0};
    endfunction

    function automatic logic [W-1:0] m_row0();
        logic [W-1:0] v;
        for (int j = 0; j < vl; j++) v[j*XLEN +: XLEN] = m_c[0][j];
        return v;
    endfunction

    task automatic m_clear();
        for (int r = 0; r < ml; r++)
            for (int j = 0; j < vl; j++) m_c[r][j] = '0;
        load_left = 0;
    endtask

    // One clock: drive, check combinational outputs mid-cycle, then advance the model at the edge.
    task automatic cyc(input logic cv, input logic ab, input logic [ml*XLEN-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] c);
        bit ld, acc;
        c_valid = cv; ab_valid = ab; vi_a = a; vi_b = b; vi_c = c;
        @(negedge clk);
        ld  = (load_left > 0);
        acc = ab && !ld && !cv;
        chk("en_c", W'(en_c), W'(ld));
        chk("en_ab", W'(en_ab), W'(acc));
        chk("vo_c", vo_c, m_row0());
`ifdef OPACC_BUSY_EN
        chk("busy", W'(busy), W'(ld || cv));
`endif
        obs_vo = vo_c;
        obs_en_c = en_c;
        @(posedge clk);
        if (ld) begin
            for (int r = 0; r < ml - 1; r++) m_c[r] = m_c[r+1];
            for (int j = 0; j < vl; j++) m_c[ml-1][j] = c[j*XLEN +: XLEN];
            load_left--;
        end else if (acc) begin
            for (int r = 0; r < ml; r++)
                for (int j = 0; j < vl; j++)
                    m_c[r][j] = m_c[r][j] + a[r*XLEN +: XLEN] * b[j*XLEN +: XLEN];
        end
        if (!ld && cv) load_left = ml;
        #1;
    endtask

    initial begin
        bit [XLEN-1:0] ones;
        ones = '1;
        reset_n = 1'b0; c_valid = 0; ab_valid = 0; vi_a = '0; vi_b = '0; vi_c = '0;
        m_clear();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_vo", vo_c, '0);
        chk("rst_en_c", W'(en_c), '0);
        chk("rst_en_ab", W'(en_ab), '0);
        @(posedge clk); #1;

        // Load rows with element j = i*j, with ab_valid colliding on the start cycle.
        cyc(1, 1, '0, pk(1, 1), '0);
        cyc(0, 1, '0, '0, pk(0, 0));
        cyc(1, 0, '0, '0, pk(1, 0));
        cyc(0, 0, '0, '0, '0);
        chk("load_done_en_c", W'(obs_en_c), '0);

        // Accumulate k=1..3, a[i]=i*k, b[j]=j*k.
        for (int k = 1; k <= 3; k++)
            cyc(0, 1, {64'(k), 64'd0}, pk(64'(k), 64'd0), '0);
        cyc(1, 0, '0, '0, '0);
        cyc(0, 0, '0, '0, pk(6, 5));
        chk("acc_row0", obs_vo, pk(0, 0));
        cyc(0, 0, '0, '0, pk(8, 7));
        chk("acc_row1", obs_vo, pk(15, 0));

        // Drain overlap: the {5,6},{7,8} C just loaded comes out during the reload.
        cyc(1, 0, '0, '0, '0);
        cyc(0, 0, '0, '0, pk(ones, ones));
        chk("drain_r0", obs_vo, pk(6, 5));
        cyc(0, 0, '0, '0, pk(ones, ones));
        chk("drain_r1", obs_vo, pk(8, 7));

        // Overflow: all-ones + 1*1 wraps to zero.
        cyc(0, 1, {64'd1, 64'd1}, pk(1, 1), '0);
        cyc(1, 0, '0, '0, '0);
        cyc(0, 0, '0, '0, '0);
        chk("ovf_r0", obs_vo, '0);
        cyc(0, 0, '0, '0, '0);
        chk("ovf_r1", obs_vo, '0);

        // Reset in the middle of a load aborts it and clears C.
        cyc(0, 0, '0, '0, '0);
        cyc(1, 0, '0, '0, '0);
        cyc(0, 0, '0, '0, pk(9, 9));
        reset_n = 1'b0;
        #2;
        chk("midrst_en_c", W'(en_c), '0);
        chk("midrst_vo", vo_c, '0);
        m_clear();
        @(posedge clk); #1 reset_n = 1'b1;
        cyc(0, 0, '0, '0, pk(3, 3));

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            logic [ml*XLEN-1:0] a;
            logic [W-1:0] b, c;
            for (int i = 0; i < ml; i++)
                a[i*XLEN +: XLEN] = ($urandom_range(3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(100));
            for (int j = 0; j < vl; j++) begin
                b[j*XLEN +: XLEN] = ($urandom_range(3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(100));
                c[j*XLEN +: XLEN] = {$urandom, $urandom};
            end
            cyc(($urandom_range(7) == 0), $urandom_range(1) == 1, a, b, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
